// File: rtl/ddr_ins_reader.sv
// ----------------------------------------------------------------------------
// ddr_ins_reader
//
// DDR-side read engine for the instruction cache. A burst request (start
// address + beat count) is latched, then one single-beat read command per
// instruction is issued to the DDR application interface. Every returned word
// is packed as {data[ISA_WIDTH-1:0], beat_idx[7:0], 1'b1} and written into the
// DDR-to-instruction-cache FIFO. ins_reading is high for the whole transfer
// and acts as the cache's acknowledgement to drop ins_read_req.
//
// Ports:
//   clk               clock
//   rst               asynchronous reset, active low
//   ins_read_req      burst request from the cache (level)
//   ins_read_addr     burst start address, sampled on accept
//   ins_read_len      number of beats, sampled on accept
//   ins_reading       transfer in progress (registered)
//   app_cmd_valid     read command valid
//   app_cmd_rdy       DDR accepts the command
//   app_addr          command address
//   app_rd_data       returned read data
//   app_rd_data_valid returned data valid
//   fifo_din          packed FIFO word
//   fifo_wr_en        FIFO write strobe
//   fifo_prog_full    FIFO cannot absorb MAX_OUT more words
//   rd_err            sticky: data beat arrived while no transfer was active
// ----------------------------------------------------------------------------
module ddr_ins_reader #(
   parameter int ISA_WIDTH      = 30,
   parameter int DDR_ADDR_WIDTH = 28,
   parameter int DDR_DATA_WIDTH = 64,
   parameter int DDR_ADDR_STEP  = 8,
   parameter int MAX_OUT        = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ins_read_req,
   input  logic [DDR_ADDR_WIDTH-1:0] ins_read_addr,
   input  logic [7:0]                ins_read_len,
   output logic                      ins_reading,
   output logic                      app_cmd_valid,
   input  logic                      app_cmd_rdy,
   output logic [DDR_ADDR_WIDTH-1:0] app_addr,
   input  logic [DDR_DATA_WIDTH-1:0] app_rd_data,
   input  logic                      app_rd_data_valid,
   output logic [ISA_WIDTH+8:0]      fifo_din,
   output logic                      fifo_wr_en,
   input  logic                      fifo_prog_full,
   output logic                      rd_err
);

   localparam int OUT_W = $clog2(MAX_OUT + 1);

   typedef enum logic [1:0] {IDLE, CMD, WAIT_DATA, DONE} state_t;

   state_t                    state_reg;
   logic [DDR_ADDR_WIDTH-1:0] cur_addr_reg;
   logic [7:0]                len_reg;
   logic [7:0]                cmd_cnt_reg;
   logic [7:0]                beat_cnt_reg;
   logic [OUT_W-1:0]          out_cnt_reg;

   logic cmd_fire;
   logic beat_in;
   logic beat_last;
   logic cmd_last;
   logic active;

   // Only the low ISA_WIDTH bits of a DDR word carry an instruction.
   generate
      if (DDR_DATA_WIDTH > ISA_WIDTH) begin : g_spare_data
         logic unused_data_bits;
         assign unused_data_bits = ^app_rd_data[DDR_DATA_WIDTH-1:ISA_WIDTH];
      end
   endgenerate

   assign active   = (state_reg == CMD) || (state_reg == WAIT_DATA);
   assign app_addr = cur_addr_reg;

   // Combinational throttle so a full credit window or a nearly full FIFO
   // stops the very next command, not one cycle late.
   assign app_cmd_valid = (state_reg == CMD)
                        && (out_cnt_reg < OUT_W'(MAX_OUT))
                        && !fifo_prog_full;

   assign cmd_fire  = app_cmd_valid && app_cmd_rdy;
   assign beat_in   = app_rd_data_valid && active;
   assign cmd_last  = ({1'b0, cmd_cnt_reg} + 9'd1) == {1'b0, len_reg};
   assign beat_last = beat_in && (({1'b0, beat_cnt_reg} + 9'd1) == {1'b0, len_reg});

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         cur_addr_reg <= '0;
         len_reg      <= '0;
         cmd_cnt_reg  <= '0;
         beat_cnt_reg <= '0;
         out_cnt_reg  <= '0;
         ins_reading  <= 1'b0;
         fifo_din     <= '0;
         fifo_wr_en   <= 1'b0;
         rd_err       <= 1'b0;
      end else begin
         fifo_wr_en <= 1'b0;

         // A beat with no transfer open is dropped and flagged.
         if (app_rd_data_valid && !active)
            rd_err <= 1'b1;

         // Data path runs regardless of whether commands are still going out.
         if (beat_in) begin
            fifo_din     <= {app_rd_data[ISA_WIDTH-1:0], beat_cnt_reg, 1'b1};
            fifo_wr_en   <= 1'b1;
            beat_cnt_reg <= beat_cnt_reg + 8'd1;
         end

         if (cmd_fire) begin
            cur_addr_reg <= cur_addr_reg + DDR_ADDR_WIDTH'(DDR_ADDR_STEP);
            cmd_cnt_reg  <= cmd_cnt_reg + 8'd1;
         end

         // Outstanding credits; a stray beat never drives the count negative.
         case ({cmd_fire, beat_in && (out_cnt_reg != '0)})
            2'b10:   out_cnt_reg <= out_cnt_reg + OUT_W'(1);
            2'b01:   out_cnt_reg <= out_cnt_reg - OUT_W'(1);
            default: out_cnt_reg <= out_cnt_reg;
         endcase

         case (state_reg)
            IDLE: begin
               if (ins_read_req) begin
                  cur_addr_reg <= ins_read_addr;
                  len_reg      <= ins_read_len;
                  cmd_cnt_reg  <= '0;
                  beat_cnt_reg <= '0;
                  ins_reading  <= 1'b1;
                  state_reg    <= (ins_read_len != 8'd0) ? CMD : DONE;
               end
            end
            CMD: begin
               if (cmd_fire && cmd_last)
                  state_reg <= WAIT_DATA;
            end
            WAIT_DATA: begin
               if (beat_last || (beat_cnt_reg == len_reg))
                  state_reg <= DONE;
            end
            DONE: begin
               // ins_reading drops one cycle after the final write (or after
               // accept for a zero-length burst); a held request is ignored.
               ins_reading <= 1'b0;
               if (!ins_read_req)
                  state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
